// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
package mem_access_pkg;

  localparam int unsigned ALU_OP_W = 8;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LB  = 8'b1110_0000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LH  = 8'b1110_0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LW  = 8'b1110_0011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SB  = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SH  = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SW  = 8'b1110_1011;

  localparam int unsigned DM_TIMEOUT = 255;

  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_RESP} mem_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_OP_LB, ALU_OP_LH, ALU_OP_LW,
      ALU_OP_SB, ALU_OP_SH, ALU_OP_SW: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_OP_SB, ALU_OP_SH, ALU_OP_SW: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic mem_size_e op_size(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_OP_LB, ALU_OP_SB: return SZ_B;
      ALU_OP_LH, ALU_OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Byte-lane steering for stores and lane extraction with sign-extension for loads.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte and halfword out of the load word.
  always_comb begin
    lane_b = rdata[7:0];
    lane_h = rdata[15:0];
    case (a)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    if (a[1]) lane_h = rdata[31:16];
  end

  // Byte enables, replicated store data and sign-extended load value by size.
  always_comb begin
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = rdata;
    case (size)
      SZ_B: begin
        be      = 4'b0001 << a;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        be      = a[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage unit: completes loads/stores over a req/ack port, passes other ops to WB.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = DM_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [ALU_OP_W-1:0] aluop_i,
  input  logic [4:0]          wd_i,
  input  logic                wreg_i,
  input  logic [31:0]         wdata_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         reg2_i,
  output logic                stallreq_o,
  output logic                dm_req_o,
  output logic                dm_we_o,
  output logic [3:0]          dm_be_o,
  output logic [31:0]         dm_addr_o,
  output logic [31:0]         dm_wdata_o,
  input  logic                dm_ack_i,
  input  logic [31:0]         dm_rdata_i,
  output logic                valid_o,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [31:0]         wdata_o,
  output logic                addr_err_o,
  output logic                bus_err_o,
  output logic [31:0]         badvaddr_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e  state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q, wreg_q;
  logic [4:0]  wd_q;
  mem_size_e   size_q;

  mem_size_e   size_i;
  logic        mem_op, mis, accept;
  logic [1:0]  lane_size, lane_a;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ld;

  // Classify the incoming EX instruction.
  always_comb begin
    size_i = op_size(aluop_i);
    mem_op = valid_i && is_mem_op(aluop_i);
    mis    = mem_op && misaligned(size_i, mem_addr_i[1:0]);
    accept = mem_op && !mis;
  end

  // One aligner serves both directions: live EX fields in IDLE, latched ones while awaiting the load word.
  assign lane_size = (state == MEM_IDLE) ? size_i : size_q;
  assign lane_a    = (state == MEM_IDLE) ? mem_addr_i[1:0] : addr_q[1:0];

  mem_lane_align u_align (
    .size    (lane_size),
    .a       (lane_a),
    .st_data (reg2_i),
    .rdata   (dm_rdata_i),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .ld_data (lane_ld)
  );

  assign dm_req_o   = (state == MEM_REQ);
  assign dm_we_o    = we_q;
  assign dm_be_o    = be_q;
  assign dm_addr_o  = {addr_q[31:2], 2'b00};
  assign dm_wdata_o = wdata_q;
  assign stallreq_o = ((state == MEM_IDLE) && accept) || (state == MEM_REQ);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: ack beats timeout when both land in the same REQ cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (accept) state_nxt = MEM_REQ;
      MEM_REQ: begin
        if (dm_ack_i)             state_nxt = MEM_RESP;
        else if (cnt == CNT_LAST) state_nxt = MEM_IDLE;
      end
      MEM_RESP: state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // Request latches, REQ cycle counter and registered WB/error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      wreg_q     <= 1'b0;
      wd_q       <= '0;
      size_q     <= SZ_B;
      valid_o    <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      badvaddr_o <= '0;
    end else begin
      valid_o    <= 1'b0;
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (mis) begin
            valid_o    <= 1'b1;
            wd_o       <= wd_i;
            wreg_o     <= 1'b0;
            wdata_o    <= wdata_i;
            addr_err_o <= 1'b1;
            badvaddr_o <= mem_addr_i;
          end else if (accept) begin
            cnt     <= '0;
            addr_q  <= mem_addr_i;
            be_q    <= lane_be;
            wdata_q <= lane_wdata;
            we_q    <= is_store(aluop_i);
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
            size_q  <= size_i;
          end else begin
            valid_o <= valid_i;
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= wdata_i;
          end
        end
        MEM_REQ: begin
          if (dm_ack_i) begin
            valid_o <= 1'b1;
            wd_o    <= wd_q;
            wreg_o  <= we_q ? 1'b0 : wreg_q;
            wdata_o <= we_q ? '0 : lane_ld;
          end else if (cnt == CNT_LAST) begin
            valid_o    <= 1'b1;
            wd_o       <= wd_q;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            bus_err_o  <= 1'b1;
            badvaddr_o <= addr_q;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed vectors, decoupled request/WB monitors.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, mem_addr_i, reg2_i;
  logic        stallreq_o, dm_req_o, dm_we_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic        dm_ack_i;
  logic [31:0] dm_rdata_i;
  logic        valid_o, wreg_o, addr_err_o, bus_err_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o, badvaddr_o;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .wd_i(wd_i),
    .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .stallreq_o(stallreq_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_be_o(dm_be_o),
    .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_ack_i(dm_ack_i),
    .dm_rdata_i(dm_rdata_i), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o),
    .badvaddr_o(badvaddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        aerr;
    logic        berr;
    logic [31:0] bad;
  } wb_t;

  req_t        req_q[$];
  wb_t         wb_q[$];
  req_t        cur_req;
  logic        have_req = 1'b0;
  int          passed = 0;
  int          total = 0;
  int unsigned cyc = 0;
  int          lat = 0;
  int          req_len = 0;
  int          last_req_len = 0;
  logic        force_ack = 1'b0;
  logic [31:0] rdata_v = '0;
  logic [31:0] exp_bad = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory responder and request monitor.
  always @(negedge clk) begin
    if (dm_req_o) begin
      req_len++;
      if (req_len == 1) begin
        if (req_q.size() == 0) begin
          total++;
          have_req = 1'b0;
          $display("FAIL unexpected_req: got request to 0x%08h, expected none", dm_addr_o);
        end else begin
          cur_req  = req_q.pop_front();
          have_req = 1'b1;
        end
      end
      if (have_req) begin
        check("req_addr",  dm_addr_o, cur_req.addr);
        check("req_be",    32'(dm_be_o), 32'(cur_req.be));
        check("req_we",    32'(dm_we_o), 32'(cur_req.we));
        check("req_wdata", dm_wdata_o, cur_req.wdata);
      end
      dm_ack_i = force_ack || (lat != 0 && req_len == lat);
    end else begin
      if (req_len != 0) last_req_len = req_len;
      req_len  = 0;
      dm_ack_i = force_ack;
    end
    dm_rdata_i = rdata_v;
  end

  // Write-back monitor.
  always @(negedge clk) begin
    if (!rst && (valid_o || addr_err_o || bus_err_o)) begin
      if (wb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_wb: got valid_o=%0b wd_o=%0d wdata_o=0x%08h, expected no output", valid_o, wd_o, wdata_o);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_cycle",    cyc, e.cyc);
        check("wb_valid",    32'(valid_o), 32'd1);
        check("wb_wd",       32'(wd_o), 32'(e.wd));
        check("wb_wreg",     32'(wreg_o), 32'(e.wreg));
        check("wb_addr_err", 32'(addr_err_o), 32'(e.aerr));
        check("wb_bus_err",  32'(bus_err_o), 32'(e.berr));
        check("wb_badvaddr", badvaddr_o, e.bad);
        if (e.chk_data) check("wb_wdata", wdata_o, e.wdata);
      end
    end
  end

  // Issue one instruction, hold it while stalled, and queue its expected responses.
  task automatic run_vec(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] wdat, input logic [4:0] wd, input logic wreg,
                         input int l, input logic [31:0] rd,
                         input logic has_req, input logic [31:0] r_addr, input logic [3:0] r_be,
                         input logic r_we, input logic [31:0] r_wdata,
                         input int unsigned wb_lat, input logic x_wreg, input logic [31:0] x_wdata,
                         input logic x_chk, input logic x_aerr, input logic x_berr,
                         input int exp_stall, input logic abort);
    req_t r;
    wb_t  w;
    int   stalls;
    int   n;
    logic s;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wdata_i = wdat; wd_i = wd; wreg_i = wreg;
    lat = l; rdata_v = rd;
    if (has_req) begin
      r.addr = r_addr; r.be = r_be; r.we = r_we; r.wdata = r_wdata;
      req_q.push_back(r);
    end
    if (x_aerr || x_berr) exp_bad = addr;
    w.cyc = cyc + wb_lat; w.wd = wd; w.wreg = x_wreg; w.wdata = x_wdata;
    w.chk_data = x_chk; w.aerr = x_aerr; w.berr = x_berr; w.bad = exp_bad;
    wb_q.push_back(w);
    stalls = 0;
    n = 0;
    forever begin
      if (abort && !dm_req_o && stalls > 0) valid_i = 1'b0;
      #1;
      s = stallreq_o;
      if (s) stalls++;
      @(posedge clk);
      if (!s) break;
      n++;
      if (n > 300) begin
        $display("FAIL stall_bound: got stallreq_o stuck high, expected release within 300 cycles");
        break;
      end
      @(negedge clk);
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; aluop_i = ALU_OP_NOP; wd_i = '0; wreg_i = 1'b0;
    wdata_i = '0; mem_addr_i = '0; reg2_i = '0; dm_ack_i = 1'b0; dm_rdata_i = '0;
    repeat (2) @(negedge clk);
    check("rst_valid_o",   32'(valid_o), 32'd0);
    check("rst_dm_req_o",  32'(dm_req_o), 32'd0);
    check("rst_stallreq",  32'(stallreq_o), 32'd0);
    check("rst_wdata_o",   wdata_o, 32'd0);
    check("rst_badvaddr",  badvaddr_o, 32'd0);
    check("rst_dm_addr",   dm_addr_o, 32'd0);
    rst = 1'b0;

    //      op         addr          reg2          wdat          wd     wr  lat rdata         req  r_addr        r_be     we    r_wdata       wbl x_wr  x_wdata       chk  aerr  berr  stl abort
    run_vec(ALU_OP_OR, 32'h0,        32'h0,        32'h0000_1234, 5'd5,  1, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_vec(ALU_OP_LB, 32'h0000_1003, 32'h0,       32'h0,        5'd3,  1, 2, 32'h80FF_0000, 1'b1, 32'h0000_1000, 4'b1000, 1'b0, 32'h0,        3, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 3, 1'b0);
    run_vec(ALU_OP_SH, 32'h0000_2002, 32'hABCD_1234, 32'h0,      5'd4,  1, 1, 32'h0,        1'b1, 32'h0000_2000, 4'b1100, 1'b1, 32'h1234_1234, 2, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_vec(ALU_OP_LW, 32'h0000_3001, 32'h0,       32'h0,        5'd6,  1, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_vec(ALU_OP_OR, 32'h0,        32'h0,        32'hCAFE_0001, 5'd7,  1, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_vec(ALU_OP_LH, 32'h0000_4002, 32'h0,       32'h0,        5'd8,  1, 1, 32'h7FFF_0000, 1'b1, 32'h0000_4000, 4'b1100, 1'b0, 32'h0,        2, 1'b1, 32'h0000_7FFF, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_vec(ALU_OP_LH, 32'h0000_4000, 32'h0,       32'h0,        5'd9,  1, 3, 32'h1234_8001, 1'b1, 32'h0000_4000, 4'b0011, 1'b0, 32'h0,        4, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    run_vec(ALU_OP_SB, 32'h0000_5001, 32'h1234_56A5, 32'h0,      5'd10, 1, 1, 32'h0,        1'b1, 32'h0000_5000, 4'b0010, 1'b1, 32'hA5A5_A5A5, 2, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_vec(ALU_OP_SW, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,      5'd1,  1, 2, 32'h0,        1'b1, 32'h0000_6000, 4'b1111, 1'b1, 32'hDEAD_BEEF, 3, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 3, 1'b0);
    run_vec(ALU_OP_LW, 32'h0000_7000, 32'h0,       32'h0,        5'd11, 1, 1, 32'h1234_5678, 1'b1, 32'h0000_7000, 4'b1111, 1'b0, 32'h0,        2, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_vec(ALU_OP_LB, 32'h0000_8000, 32'h0,       32'h0,        5'd2,  1, 1, 32'hFFFF_FF7F, 1'b1, 32'h0000_8000, 4'b0001, 1'b0, 32'h0,        2, 1'b1, 32'h0000_007F, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_vec(ALU_OP_SH, 32'h0000_2001, 32'h5555_AAAA, 32'h0,      5'd12, 1, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_vec(ALU_OP_LW, 32'h0000_A000, 32'h0,       32'h0,        5'd14, 1, 0, 32'h0,        1'b1, 32'h0000_A000, 4'b1111, 1'b0, 32'h0,        9, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 9, 1'b1);
    check("timeout_req_cycles", 32'(last_req_len), 32'd8);
    run_vec(ALU_OP_OR, 32'h0,        32'h0,        32'h0000_0000, 5'd13, 0, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Reset during the second REQ cycle, then a late ack.
    @(negedge clk);
    valid_i = 1'b1; aluop_i = ALU_OP_LW; mem_addr_i = 32'h0000_9000; reg2_i = '0;
    wd_i = 5'd15; wreg_i = 1'b1; lat = 0; rdata_v = 32'hFFFF_FFFF;
    begin
      req_t r;
      r.addr = 32'h0000_9000; r.be = 4'b1111; r.we = 1'b0; r.wdata = '0;
      req_q.push_back(r);
    end
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    exp_bad = '0;
    check("rst_mid_req_ctl", 32'({valid_o, dm_req_o, stallreq_o, wreg_o, addr_err_o, bus_err_o, dm_we_o, dm_be_o, wd_o}), 32'd0);
    check("rst_mid_req_wdata", wdata_o, 32'd0);
    check("rst_mid_req_bad", badvaddr_o, 32'd0);
    check("rst_mid_req_addr", dm_addr_o, 32'd0);
    check("rst_mid_req_dwdata", dm_wdata_o, 32'd0);
    @(negedge clk);
    force_ack = 1'b0;
    check("late_ack_valid", 32'(valid_o), 32'd0);
    check("late_ack_req",   32'(dm_req_o), 32'd0);

    run_vec(ALU_OP_OR, 32'h0,        32'h0,        32'h0000_55AA, 5'd16, 1, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,        1, 1'b1, 32'h0000_55AA, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("wb_queue_drained",  32'(wb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
